// File: rtl/sprite_palette_bank.sv
// Multi-bank runtime-writable sprite palette: index -> RGB through a 2-stage pipeline,
// with per-frame bank latch, transparency, a frame-timed flash overlay and a clear engine.

module sprite_palette_bank_ram #(
  parameter int INDEX_W = 4,
  parameter int RGB_W   = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_en,
  input  logic [INDEX_W-1:0]             clr_ptr,
  input  logic                           wr_en,
  input  logic [INDEX_W-1:0]             wr_index,
  input  logic [RGB_W-1:0]               wr_rgb,
  output logic [(2**INDEX_W)-1:0][RGB_W-1:0] mem
);
  // Register-based so the whole palette resets to black and every entry is readable in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem           <= '0;
    else if (clr_en) mem[clr_ptr]  <= '0;
    else if (wr_en)  mem[wr_index] <= wr_rgb;
  end
endmodule

module sprite_palette_bank #(
  parameter int INDEX_W      = 4,
  parameter int NUM_BANKS    = 4,
  parameter int CH_W         = 4,
  parameter int TRANSP_INDEX = 0,
  parameter int FLASH_FRAMES = 8,
  localparam int BANK_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [BANK_W-1:0]    bank_sel,
  input  logic                 transp_en,
  input  logic                 flash_trigger,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   pix_index,
  output logic                 out_valid,
  output logic                 out_transparent,
  output logic [CH_W-1:0]      red,
  output logic [CH_W-1:0]      green,
  output logic [CH_W-1:0]      blue,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [3*CH_W-1:0]    wr_rgb,
  input  logic                 clear_req,
  output logic                 busy
);
  localparam int RGB_W = 3 * CH_W;
  localparam int DEPTH = 2 ** INDEX_W;
  localparam logic [BANK_W-1:0]  LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [INDEX_W-1:0] LAST_PTR  = INDEX_W'(DEPTH - 1);
  localparam logic [INDEX_W-1:0] T_INDEX   = INDEX_W'(TRANSP_INDEX);
  localparam logic [7:0]         FLASH_LD  = 8'(FLASH_FRAMES);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return (NUM_BANKS == 2 ** BANK_W) || (int'(b) < NUM_BANKS);
  endfunction

  logic [0:0]                                      state;
  logic [INDEX_W-1:0]                              clr_ptr;
  logic [BANK_W-1:0]                               active_bank;
  logic [7:0]                                      flash_cnt;
  logic [NUM_BANKS-1:0][DEPTH-1:0][RGB_W-1:0]      mem;
  logic                                            wr_fire;
  logic                                            clr_en;

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);
  assign clr_en   = (state == CLEAR);
  assign wr_fire  = wr_valid && wr_ready && bank_ok(wr_bank);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sprite_palette_bank_ram #(.INDEX_W(INDEX_W), .RGB_W(RGB_W)) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_en   (clr_en),
      .clr_ptr  (clr_ptr),
      .wr_en    (wr_fire && (wr_bank == BANK_W'(g))),
      .wr_index (wr_index),
      .wr_rgb   (wr_rgb),
      .mem      (mem[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (clear_req) begin
          state   <= CLEAR;
          clr_ptr <= '0;
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_PTR) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A trigger coinciding with frame_start reloads rather than decrements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank <= '0;
      flash_cnt   <= '0;
    end else begin
      if (frame_start) active_bank <= bank_ok(bank_sel) ? bank_sel : LAST_BANK;
      if (flash_trigger)                         flash_cnt <= FLASH_LD;
      else if (frame_start && flash_cnt != 8'd0) flash_cnt <= flash_cnt - 8'd1;
    end
  end

  logic               s1_valid;
  logic [INDEX_W-1:0] s1_index;
  logic [BANK_W-1:0]  s1_bank;
  logic               s1_transp_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_index     <= '0;
      s1_bank      <= '0;
      s1_transp_en <= 1'b0;
    end else begin
      s1_valid     <= pix_valid;
      s1_index     <= pix_index;
      s1_bank      <= active_bank;
      s1_transp_en <= transp_en;
    end
  end

  logic [RGB_W-1:0] lut;
  logic             is_transp;
  logic [CH_W-1:0]  r_n, g_n, b_n;

  // Lookup reads the array before this edge's write lands, so collisions return the old entry.
  always_comb begin
    lut       = mem[s1_bank][s1_index];
    is_transp = s1_transp_en && (s1_index == T_INDEX);
    r_n       = lut[RGB_W-1 -: CH_W];
    g_n       = lut[2*CH_W-1 -: CH_W];
    b_n       = lut[CH_W-1:0];
    if (is_transp) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end else if (flash_cnt != 8'd0) begin
      r_n = '1;
      g_n = g_n >> 1;
      b_n = b_n >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_transparent <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
    end else begin
      out_valid       <= s1_valid;
      out_transparent <= s1_valid && is_transp;
      if (s1_valid) begin
        red   <= r_n;
        green <= g_n;
        blue  <= b_n;
      end
    end
  end
endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-bank successor to the fixed per-sprite palette ROMs.
- Maps a pixel's palette index to RGB through a 2-stage registered pipeline.
- Bank select is latched per frame, and one palette index can be treated as transparent.
- A damage "flash" overlay is timed in frames. A loader fills the RAM through a valid/ready port; a clear engine zeroes it.
- Sits between the sprite pixel fetch and the VGA colour mux.

Parameters:
- INDEX_W, 4, palette index width; each bank holds 2**INDEX_W entries.
- NUM_BANKS, 4, number of palettes (≥2). BANK_W = $clog2(NUM_BANKS) (derived localparam).
- CH_W, 4, bits per colour channel.
- TRANSP_INDEX, 0, index reported as transparent when transp_en=1.
- FLASH_FRAMES, 8, frames the flash overlay lasts (1..255).

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at frame begin (vsync edge).
- bank_sel  in  BANK_W  requested bank, sampled only on frame_start.
- transp_en  in  1  enable transparency detection.
- flash_trigger  in  1  one-cycle pulse to (re)start flash.
- pix_valid  in  1  pixel index valid this cycle.
- pix_index  in  INDEX_W  palette index.
- out_valid  out  1  pix_valid delayed 2 cycles.
- out_transparent  out  1  pixel is transparent.
- red, green, blue  out  CH_W each  looked-up colour.
- wr_valid  in  1  loader write request.
- wr_ready  out  1  loader write accepted when wr_valid & wr_ready.
- wr_bank  in  BANK_W  target bank.
- wr_index  in  INDEX_W  target entry.
- wr_rgb  in  3*CH_W  {r,g,b} to store.
- clear_req  in  1  pulse: zero all entries of all banks.
- busy  out  1  clear engine active.

Behaviour:
- Reset (async, Reset_n=0):
  - All RAM entries = 0.
  - active_bank = 0, flash counter = 0, FSM = IDLE.
  - out_valid = 0, out_transparent = 0, red/green/blue = 0.
  - busy = 0, wr_ready = 1.
  - Reset asserted mid-clear aborts the clear; all state returns to reset values.
- Bank latch:
  - On frame_start, active_bank <= bank_sel.
  - If bank_sel ≥ NUM_BANKS, active_bank <= NUM_BANKS-1.
  - Pixels in flight keep the bank captured in stage 1.
- Read pipeline, latency exactly 2 cycles, fully pipelined (one pixel per cycle, no stalls):
  - S1 registers pix_valid, pix_index, active_bank, and transp_en.
  - S2 registers the RAM lookup into red/green/blue, plus out_valid and out_transparent.
  - When S1 valid=0: out_valid=0; colour outputs hold their previous value.
- Transparency:
  - If S1 transp_en=1 and S1 index==TRANSP_INDEX, then out_transparent=1 and rgb=0.
  - Otherwise out_transparent=0.
- Read/write collision: a write to the same bank/index in the same cycle as the S2 lookup returns the OLD value; the new value is visible from the next cycle.
- Flash overlay:
  - flash_trigger loads counter = FLASH_FRAMES; a retrigger while active reloads it.
  - Each frame_start with counter>0 decrements it by 1.
  - If flash_trigger and frame_start coincide, the load wins.
  - While counter>0, non-transparent outputs have red forced to all-ones; green and blue are shifted right by 1.
  - The flash state is sampled at S2.
- FSM:
  - IDLE:
    - wr_ready=1; an accepted write updates the entry at the next edge.
    - clear_req -> CLEAR, with clr_ptr=0.
    - A write accepted in the same cycle as clear_req is performed, then cleared.
  - CLEAR:
    - wr_ready=0, busy=1.
    - Each cycle, zero entry clr_ptr in every bank and increment clr_ptr.
    - When clr_ptr==2**INDEX_W-1 -> IDLE; busy falls on the following cycle.
    - A clear therefore takes 2**INDEX_W cycles.
    - clear_req while in CLEAR is ignored.
    - The read pipeline keeps running during CLEAR; lookups return whatever is present at each edge.
- Width rules:
  - wr_rgb[3*CH_W-1 -: CH_W] = red, the middle CH_W bits = green, the low CH_W bits = blue.
  - Out-of-range wr_bank: the write is accepted and dropped.

Test Plan:
1. Reset, then write bank1 idx5 = 12'hA84; frame_start with bank_sel=1; pix_index=5 at cycle t -> out_valid=1 at t+2 with rgb = A,8,4 and out_transparent=0.
2. transp_en=1, bank0 idx0 = 12'h011; stream indices 0,3,0 back-to-back -> outputs transp/rgb0, entry3, transp/rgb0 on consecutive cycles.
3. Write idx7 = 12'h123 in the same cycle as its S2 lookup (old value 12'h000) -> output 000; next lookup of idx7 -> 123.
4. Load all 4 banks, pulse clear_req -> busy=1 and wr_ready=0 for 16 cycles; an attempted write is not accepted; afterwards every entry reads 000.
5. Entry = 12'h6A4, flash_trigger, then 8 frame_starts -> output F,5,2 until the 8th frame_start, then 6,A,4; a retrigger at frame 4 extends the flash to 8 frames from the retrigger.
6. Drop Reset_n mid-stream and mid-clear -> all outputs 0 immediately, busy=0, wr_ready=1, RAM reads 000.
